// File: rtl/lookup_rr_arbiter_pkg.sv
// Shared types and helpers for the NoC output-port round-robin arbiter.
// Holds the FSM state encoding and the one-hot to binary index conversion.
package noc_arb_pkg;

  // Widest request vector the index helper handles; NUM_REQ must not exceed it.
  localparam int ARB_MAX_REQ   = 64;
  localparam int ARB_MAX_IDX_W = 6;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Callers zero-extend their vector to ARB_MAX_REQ bits and truncate the
  // result to their own index width. An all-zero input yields index 0.
  function automatic logic [ARB_MAX_IDX_W-1:0] onehot2idx(
    input logic [ARB_MAX_REQ-1:0] onehot
  );
    logic [ARB_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < ARB_MAX_REQ; k++) begin
      if (onehot[k]) idx = idx | ARB_MAX_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lookup_rr_arbiter_rr_pick.sv
// Combinational rotate-priority pick: first requester at or after ptr_i,
// wrapping at N (not at a power of two) back to channel 0.
module rr_pick
  import noc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [N-1:0]  win_onehot_o,
  output logic [IW-1:0] win_idx_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] pick_src;

  // Requests at or above the pointer take precedence; if there are none the
  // scan has wrapped and the lowest requester overall wins.
  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      hi_mask[k] = (k >= int'(ptr_i));
    end
    hi_req   = req_i & hi_mask;
    pick_src = (|hi_req) ? hi_req : req_i;
  end

  assign any_o        = |req_i;
  assign win_onehot_o = pick_src & (~pick_src + N'(1));
  assign win_idx_o    = IW'(onehot2idx(ARB_MAX_REQ'(win_onehot_o)));

endmodule

// File: rtl/lookup_rr_arbiter.sv
// Round-robin packet arbiter for one router output port; holds each grant until
// the granted channel's last flit transfers. Optional err output: ARB_ERR_EN.
module lookup_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  input  logic               out_ready,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx
`ifdef ARB_ERR_EN
  ,
  output logic               err
`endif
);

  arb_state_t         state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [NUM_REQ-1:0] gnt_oh_q;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;

  logic               gnt_req;
  logic               gnt_last;
  logic               xfer;
  logic               xfer_last;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req_i        (req_i),
    .ptr_i        (rr_ptr_q),
    .any_o        (pick_any),
    .win_onehot_o (pick_oh),
    .win_idx_o    (pick_idx)
  );

  // Handshake: a flit moves on an edge where the granted channel's req_i
  // (valid) and out_ready are both high; neither side waits for the other,
  // and last_i is only meaningful while its req_i is set.
  assign gnt_req   = |(req_i & gnt_oh_q);
  assign gnt_last  = |(last_i & gnt_oh_q);
  assign xfer      = (state_q == ARB_LOCKED) & gnt_req & out_ready;
  assign xfer_last = xfer & gnt_last;

  assign rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

  // gnt_idx_q keeps the last winner through IDLE so the mux select stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      gnt_oh_q  <= '0;
      gnt_idx_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_oh_q  <= pick_oh;
            gnt_idx_q <= pick_idx;
            state_q   <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (xfer_last) begin
            gnt_oh_q <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ARB_IDLE;
          end
        end
        default: begin
          gnt_oh_q <= '0;
          state_q  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt_valid  = (state_q == ARB_LOCKED);
  assign gnt_onehot = gnt_oh_q;
  assign gnt_idx    = gnt_idx_q;

`ifdef ARB_ERR_EN
  logic err_q;
  logic err_d;

  assign err_d = ((state_q == ARB_LOCKED) & ~gnt_req) | (|(last_i & ~req_i));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_lookup_rr_arbiter.sv
// Directed bench for lookup_rr_arbiter: a 4-channel instance plus a 3-channel
// instance for the non-power-of-two wrap; err checks run when ARB_ERR_EN is set.
module tb_lookup_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] last_i;
  logic       out_ready;
  logic       gnt_valid;
  logic [3:0] gnt_onehot;
  logic [1:0] gnt_idx;

  logic [2:0] req3;
  logic [2:0] last3;
  logic       gnt_valid3;
  logic [2:0] gnt_onehot3;
  logic [1:0] gnt_idx3;

`ifdef ARB_ERR_EN
  logic err;
  logic err3;
`endif

  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lookup_rr_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .last_i     (last_i),
    .out_ready  (out_ready),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
`ifdef ARB_ERR_EN
    ,
    .err        (err)
`endif
  );

  lookup_rr_arbiter #(.NUM_REQ(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req3),
    .last_i     (last3),
    .out_ready  (out_ready),
    .gnt_valid  (gnt_valid3),
    .gnt_onehot (gnt_onehot3),
    .gnt_idx    (gnt_idx3)
`ifdef ARB_ERR_EN
    ,
    .err        (err3)
`endif
  );

  // Grant vector must be zero while idle and exactly the indexed bit while locked.
  always @(negedge clk) begin
    if (!reset) begin
      logic [3:0] exp_oh;
      exp_oh = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
      n_checks++;
      if (gnt_onehot !== exp_oh) begin
        n_errors++;
        $display("FAIL onehot_invariant: got %b want %b (valid=%b idx=%0d)", gnt_onehot, exp_oh, gnt_valid, gnt_idx);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_i     = '0;
    last_i    = '0;
    req3      = '0;
    last3     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_i = 4'b1111;
    last_i = '0;
    #1;
    n_checks++;
    if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
    n_checks++;
    if (gnt_onehot !== 4'b0000) begin n_errors++; $display("FAIL reset_onehot: got %b want 0000", gnt_onehot); end
    n_checks++;
    if (gnt_idx !== 2'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
`ifdef ARB_ERR_EN
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_i  = 4'b0100;
    last_i = 4'b0000;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100) begin
      n_errors++; $display("FAIL midrst_grant: got v=%b idx=%0d oh=%b want v=1 idx=2 oh=0100", gnt_valid, gnt_idx, gnt_onehot);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000 || gnt_idx !== 2'd0) begin
      n_errors++; $display("FAIL midrst_async: got v=%b idx=%0d oh=%b want all 0", gnt_valid, gnt_idx, gnt_onehot);
    end
    #1 reset = 1'b0;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100) begin
      n_errors++; $display("FAIL midrst_regrant: got v=%b idx=%0d oh=%b want v=1 idx=2 oh=0100", gnt_valid, gnt_idx, gnt_onehot);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_idx [5];
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_i     = 4'b1111;
    last_i    = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx[i] || gnt_onehot !== (4'b0001 << exp_idx[i])) begin
        n_errors++; $display("FAIL fair_grant[%0d]: got v=%b idx=%0d oh=%b want v=1 idx=%0d", i, gnt_valid, gnt_idx, gnt_onehot, exp_idx[i]);
      end
      tick();
      n_checks++;
      if (gnt_valid !== 1'b0 || gnt_idx !== exp_idx[i]) begin
        n_errors++; $display("FAIL fair_bubble[%0d]: got v=%b idx=%0d want v=0 idx=%0d", i, gnt_valid, gnt_idx, exp_idx[i]);
      end
    end
  endtask

  task automatic test_lock_hold();
    logic       rdy_seq [4];
    logic [3:0] last_seq [4];
    logic       exp_v [4];
    rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b1};
    last_seq = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    exp_v    = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    // One single-flit packet from ch0 moves the pointer to 1.
    req_i  = 4'b0001;
    last_i = 4'b0001;
    tick();
    tick();
    req_i  = 4'b1011;
    last_i = 4'b0000;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1 || gnt_onehot !== 4'b0010) begin
      n_errors++; $display("FAIL lock_grant: got v=%b idx=%0d oh=%b want v=1 idx=1 oh=0010", gnt_valid, gnt_idx, gnt_onehot);
    end
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy_seq[i];
      last_i    = last_seq[i];
      tick();
      n_checks++;
      if (gnt_valid !== exp_v[i] || gnt_idx !== 2'd1) begin
        n_errors++; $display("FAIL lock_hold[%0d]: got v=%b idx=%0d want v=%b idx=1", i, gnt_valid, gnt_idx, exp_v[i]);
      end
    end
    out_ready = 1'b1;
    last_i    = 4'b0000;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3 || gnt_onehot !== 4'b1000) begin
      n_errors++; $display("FAIL lock_next: got v=%b idx=%0d oh=%b want v=1 idx=3 oh=1000", gnt_valid, gnt_idx, gnt_onehot);
    end
  endtask

  task automatic test_nonpow2_wrap();
    do_reset();
    req3  = 3'b100;
    last3 = 3'b100;
    tick();
    n_checks++;
    if (gnt_valid3 !== 1'b1 || gnt_idx3 !== 2'd2 || gnt_onehot3 !== 3'b100) begin
      n_errors++; $display("FAIL wrap3_grant2: got v=%b idx=%0d oh=%b want v=1 idx=2 oh=100", gnt_valid3, gnt_idx3, gnt_onehot3);
    end
    tick();
    n_checks++;
    if (gnt_valid3 !== 1'b0 || gnt_onehot3 !== 3'b000) begin
      n_errors++; $display("FAIL wrap3_release: got v=%b oh=%b want v=0 oh=000", gnt_valid3, gnt_onehot3);
    end
    req3  = 3'b111;
    last3 = 3'b000;
    tick();
    n_checks++;
    if (gnt_valid3 !== 1'b1 || gnt_idx3 !== 2'd0 || gnt_onehot3 !== 3'b001) begin
      n_errors++; $display("FAIL wrap3_grant0: got v=%b idx=%0d oh=%b want v=1 idx=0 oh=001", gnt_valid3, gnt_idx3, gnt_onehot3);
    end
  endtask

`ifdef ARB_ERR_EN
  task automatic test_err();
    logic exp_err [2];
    exp_err = '{1'b1, 1'b1};
    do_reset();
    req_i  = 4'b0001;
    last_i = 4'b0000;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || err !== 1'b0) begin
      n_errors++; $display("FAIL drop_grant: got v=%b idx=%0d err=%b want v=1 idx=0 err=0", gnt_valid, gnt_idx, err);
    end
    req_i = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (gnt_valid !== 1'b1 || err !== exp_err[i]) begin
        n_errors++; $display("FAIL drop_hold[%0d]: got v=%b err=%b want v=1 err=1", i, gnt_valid, err);
      end
    end
    req_i  = 4'b0001;
    last_i = 4'b0001;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b0 || err !== 1'b0) begin
      n_errors++; $display("FAIL drop_release: got v=%b err=%b want v=0 err=0", gnt_valid, err);
    end
    req_i  = 4'b0000;
    last_i = 4'b0100;
    tick();
    n_checks++;
    if (err !== 1'b1 || gnt_valid !== 1'b0) begin
      n_errors++; $display("FAIL illegal_last: got err=%b v=%b want err=1 v=0", err, gnt_valid);
    end
    last_i = 4'b0000;
    tick();
    n_checks++;
    if (err !== 1'b0 || gnt_valid !== 1'b0) begin
      n_errors++; $display("FAIL illegal_last_clear: got err=%b v=%b want err=0 v=0", err, gnt_valid);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    req_i     = '0;
    last_i    = '0;
    req3      = '0;
    last3     = '0;
    out_ready = 1'b1;
    test_reset();
    test_reset_mid_packet();
    test_fairness();
    test_lock_hold();
    test_nonpow2_wrap();
`ifdef ARB_ERR_EN
    test_err();
`endif
    reset = 1'b1;
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
